// File: rtl/fifo_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wptr_full_ctrl
// Brief    : Write-domain pointer and full-flag controller for an async FIFO.
//            Produces the binary RAM write address, the Gray write pointer
//            for the read-domain synchronizer, and full / almost-full /
//            occupancy / sticky-overflow status from the synchronized Gray
//            read pointer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wptr_full_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  input  logic                 clr_overflow,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wcount,
  output logic                 overflow
);

  // Occupancy threshold at which almost-full is raised.
  localparam logic [ADDR_SIZE:0] C_AF_LEVEL = (ADDR_SIZE+1)'((2**ADDR_SIZE) - AF_MARGIN);

  logic [ADDR_SIZE:0] wbin_q,  wbin_d;
  logic [ADDR_SIZE:0] wptr_q,  wptr_d;
  logic               wfull_q, wfull_d;
  logic               walmost_full_q, walmost_full_d;
  logic [ADDR_SIZE:0] wcount_q, wcount_d;
  logic               overflow_q, overflow_d;

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] occ_next;
  logic [ADDR_SIZE:0] rptr_full_cmp;

  // A write is accepted only when the FIFO is not (conservatively) full.
  assign wen   = winc & ~wfull_q;
  assign waddr = wbin_q[ADDR_SIZE-1:0];

  // Gray-to-binary of the synchronized read pointer: bit i is the XOR of all
  // Gray bits at positions i and above.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  // Next-state computation for pointers and status flags.
  always_comb begin
    wbin_d   = wbin_q + {{ADDR_SIZE{1'b0}}, wen};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    occ_next = wbin_d - rbin;
    // Full when the next write pointer equals the read pointer with the two
    // MSBs inverted, i.e. exactly one lap ahead in Gray space.
    rptr_full_cmp  = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};
    wfull_d        = (wptr_d == rptr_full_cmp);
    walmost_full_d = (occ_next >= C_AF_LEVEL);
    wcount_d       = occ_next;
    // Set has priority over clear so a same-cycle overflow is never lost.
    overflow_d     = (winc & wfull_q) | (overflow_q & ~clr_overflow);
  end

  // State register; every flop is cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wcount_q       <= '0;
      overflow_q     <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wcount_q       <= wcount_d;
      overflow_q     <= overflow_d;
    end
  end

  // Outputs come straight from flops so wptr is safe to synchronize.
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wcount       = wcount_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wptr_full_ctrl
// Brief    : Self-checking bench for fifo_wptr_full_ctrl (ADDR_SIZE=4,
//            AF_MARGIN=2) using an expected-result queue fed by an
//            occupancy-counting model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wptr_full_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       clr_overflow;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Expected vector: {wen, waddr, wptr, wfull, walmost_full, wcount, overflow}
  logic [17:0] exp_q[$];
  logic        obs_wen;
  logic [3:0]  obs_waddr;

  // Model state: write/read binary positions (mod 32) and status.
  int   m_wb, m_rb;
  logic m_full, m_af, m_ovf;
  int   m_cnt;

  fifo_wptr_full_ctrl #(.ADDR_SIZE(4), .AF_MARGIN(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .clr_overflow (clr_overflow),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [17:0] observed();
    return {obs_wen, obs_waddr, wptr, wfull, walmost_full, wcount, overflow};
  endfunction

  // One clock of stimulus: drive inputs, push the model's expectation, sample
  // the combinational outputs before the edge, then advance past the edge.
  task automatic drive(input logic w, input logic clr, input int rb_new, input logic rst);
    logic       e_wen;
    logic [3:0] e_waddr;
    int         occ;
    winc         = w;
    clr_overflow = clr;
    rst_n        = ~rst;
    m_rb         = rb_new & 31;
    wq2_rptr     = gray(m_rb);
    e_wen        = w && !m_full;
    e_waddr      = 4'(m_wb);
    if (rst) begin
      m_wb = 0; m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      m_ovf  = (w && m_full) || (m_ovf && !clr);
      m_wb   = (m_wb + (e_wen ? 1 : 0)) & 31;
      occ    = (m_wb - m_rb) & 31;
      m_full = (occ == 16);
      m_af   = (occ >= 14);
      m_cnt  = occ;
    end
    exp_q.push_back({e_wen, e_waddr, gray(m_wb), m_full, m_af, 5'(m_cnt), m_ovf});
    #3;
    obs_wen   = wen;
    obs_waddr = waddr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] e, o;
    drive(1'b0, 1'b0, 0, 1'b1);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++; $display("FAIL reset: got %b want %b", o, e);
    end
    checks++;
    if ({wptr, wfull, walmost_full, wcount, overflow} !== 13'd0) begin
      errors++; $display("FAIL reset_zero: got %b want 0", {wptr, wfull, walmost_full, wcount, overflow});
    end
  endtask

  task automatic test_fill();
    logic [17:0] e, o;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0);
      e = exp_q.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL fill[%0d]: got %b want %b", i, o, e);
      end
    end
    checks++;
    if ({wfull, wptr, wcount} !== {1'b1, 5'b11000, 5'd16}) begin
      errors++; $display("FAIL fill_end: full=%b wptr=%b cnt=%0d want 1 11000 16", wfull, wptr, wcount);
    end
  endtask

  task automatic test_overflow();
    logic [17:0] e, o;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0);
      e = exp_q.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL ovf_write[%0d]: got %b want %b", i, o, e);
      end
    end
    checks++;
    if ({overflow, wptr} !== {1'b1, 5'b11000}) begin
      errors++; $display("FAIL ovf_hold: ovf=%b wptr=%b want 1 11000", overflow, wptr);
    end
    drive(1'b0, 1'b1, 0, 1'b0);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want %b", o, e);
    end
    drive(1'b1, 1'b1, 0, 1'b0);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins: got %b want %b", o, e);
    end
  endtask

  task automatic test_one_read();
    logic [17:0] e, o;
    drive(1'b0, 1'b0, 1, 1'b0);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e || {wfull, wcount, walmost_full} !== {1'b0, 5'd15, 1'b1}) begin
      errors++; $display("FAIL one_read: got %b want %b", o, e);
    end
    drive(1'b1, 1'b0, 1, 1'b0);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e || {wfull, wptr} !== {1'b1, 5'b11001}) begin
      errors++; $display("FAIL refill: got %b want %b", o, e);
    end
  endtask

  task automatic test_streaming();
    logic [17:0] e, o;
    logic [4:0]  prev;
    for (int r = 2; r <= 14; r++) begin
      drive(1'b0, 1'b0, r, 1'b0);
      e = exp_q.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL drain[%0d]: got %b want %b", r, o, e);
      end
    end
    for (int i = 0; i < 40; i++) begin
      prev = wptr;
      drive(1'b1, 1'b0, m_rb + 1, 1'b0);
      e = exp_q.pop_front(); o = observed(); checks++;
      if (o !== e || wcount !== 5'd3 || wfull !== 1'b0) begin
        errors++; $display("FAIL stream[%0d]: got %b want %b", i, o, e);
      end
      checks++;
      if ($countones(wptr ^ prev) != 1) begin
        errors++; $display("FAIL stream_gray[%0d]: got %b from %b want one-bit step", i, wptr, prev);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e, o;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, m_rb, 1'b0);
      e = exp_q.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL b2b_fill[%0d]: got %b want %b", i, o, e);
      end
    end
    drive(1'b1, 1'b0, m_rb + 1, 1'b0);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e || {wcount, wfull} !== {5'd8, 1'b0}) begin
      errors++; $display("FAIL same_cycle: got %b want %b", o, e);
    end
  endtask

  task automatic test_mid_reset();
    logic [17:0] e, o;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, m_rb, 1'b0);
      e = exp_q.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL pre_rst[%0d]: got %b want %b", i, o, e);
      end
    end
    checks++;
    if (wcount !== 5'd10 || overflow !== 1'b1) begin
      errors++; $display("FAIL pre_rst_state: cnt=%0d ovf=%b want 10 1", wcount, overflow);
    end
    drive(1'b1, 1'b0, 0, 1'b1);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e || {wptr, wfull, walmost_full, wcount, overflow} !== 13'd0) begin
      errors++; $display("FAIL mid_reset: got %b want %b", o, e);
    end
    drive(1'b1, 1'b0, 0, 1'b0);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e || obs_wen !== 1'b1) begin
      errors++; $display("FAIL post_rst_wen: got %b want %b", o, e);
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    e = exp_q.pop_front(); o = observed(); checks++;
    if (o !== e || obs_wen !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle: got %b want %b", o, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; clr_overflow = 1'b0; wq2_rptr = '0;
    m_wb = 0; m_rb = 0; m_full = 0; m_af = 0; m_ovf = 0; m_cnt = 0;
    obs_wen = 1'b0; obs_waddr = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_one_read();
    test_streaming();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
